// File: rtl/writeback_select_unit.sv
// Register-file writeback selector: picks one of NUM_SRC sources, waits for it
// to become valid, then issues a single registered write to the register bank.
module writeback_select_unit #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_SRC     = 7,
  parameter int          SEL_W       = 3,
  parameter int          CONST_SEL   = 5,
  parameter int unsigned CONST_VALUE = 227,
  parameter int          ADDR_W      = 5,
  parameter int          TIMEOUT     = 63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wb_req,
  input  logic [SEL_W-1:0]          wb_sel,
  input  logic [ADDR_W-1:0]         wb_dest,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      wb_en,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int NUM_SLOT = 2 ** SEL_W;
  localparam int CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DATA_W-1:0] CONST_WORD = DATA_W'(CONST_VALUE);
  localparam logic [SEL_W:0]    SRC_LIMIT  = (SEL_W + 1)'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [ADDR_W-1:0]   dest_reg, dest_next;
  logic                wb_en_reg, wb_en_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                capture;

  // Every select code maps to a slot so indexing never leaves the array;
  // codes past NUM_SRC read as never-valid zero.
  logic [DATA_W-1:0]   slot_data [NUM_SLOT];
  logic [NUM_SLOT-1:0] slot_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      if (gi == CONST_SEL) begin : g_const
        logic [DATA_W-1:0] unused_data;
        logic              unused_valid;
        if (gi < NUM_SRC) begin : g_tap
          assign unused_data  = src_data[gi*DATA_W +: DATA_W];
          assign unused_valid = src_valid[gi];
        end else begin : g_notap
          assign unused_data  = '0;
          assign unused_valid = 1'b0;
        end
        assign slot_data[gi] = CONST_WORD;
        assign slot_ok[gi]   = 1'b1;
      end else if (gi < NUM_SRC) begin : g_src
        assign slot_data[gi] = src_data[gi*DATA_W +: DATA_W];
        assign slot_ok[gi]   = src_valid[gi];
      end else begin : g_none
        assign slot_data[gi] = '0;
        assign slot_ok[gi]   = 1'b0;
      end
    end
  endgenerate

  // In IDLE the live request selects; afterwards the latched select does.
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] sel_word;
  logic              sel_ok;
  logic              sel_bad;

  assign rd_sel   = (state_reg == ST_IDLE) ? wb_sel : sel_reg;
  assign sel_word = slot_data[rd_sel];
  assign sel_ok   = slot_ok[rd_sel];
  assign sel_bad  = ({1'b0, wb_sel} >= SRC_LIMIT);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sel_next   = sel_reg;
    dest_next  = dest_reg;
    capture    = 1'b0;
    error_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (wb_req) begin
          sel_next  = wb_sel;
          dest_next = wb_dest;
          if (sel_bad) begin
            error_next = 1'b1;
          end else if (sel_ok) begin
            capture    = 1'b1;
            state_next = ST_WRITE;
          end else begin
            state_next = ST_WAIT;
            count_next = '0;
          end
        end
      end
      ST_WAIT: begin
        if (sel_ok) begin
          capture    = 1'b1;
          state_next = ST_WRITE;
        end else if ((TIMEOUT != 0) && (count_reg == CNT_LAST)) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything except reset.
    if (flush) begin
      state_next = ST_IDLE;
      sel_next   = sel_reg;
      dest_next  = dest_reg;
      capture    = 1'b0;
      error_next = 1'b0;
    end

    wb_en_next = capture && (dest_next != '0);
    done_next  = capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      sel_reg   <= '0;
      dest_reg  <= '0;
      wb_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sel_reg   <= sel_next;
      dest_reg  <= dest_next;
      wb_en_reg <= wb_en_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      if (capture) begin
        addr_reg <= dest_next;
        data_reg <= sel_word;
      end
    end
  end

  assign wb_en   = wb_en_reg;
  assign done    = done_reg;
  assign error   = error_reg;
  assign wb_addr = addr_reg;
  assign wb_data = data_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_writeback_select_unit.sv
// Bench for writeback_select_unit: directed scenarios then random transactions,
// each checked cycle by cycle against a transaction-level outcome model.
module tb_writeback_select_unit;

  localparam int TOUT = 16;
  localparam int NSRC = 7;
  localparam int CSEL = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          wb_req;
  logic [2:0]    wb_sel;
  logic [4:0]    wb_dest;
  logic [NSRC*32-1:0] src_data;
  logic [NSRC-1:0]    src_valid;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad = 0;
  int txn_no = 0;
  logic [31:0] mod_addr;
  logic [31:0] mod_data;

  writeback_select_unit #(
    .DATA_W(32), .NUM_SRC(NSRC), .SEL_W(3), .CONST_SEL(CSEL),
    .CONST_VALUE(227), .ADDR_W(5), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_req(wb_req),
    .wb_sel(wb_sel), .wb_dest(wb_dest), .src_data(src_data),
    .src_valid(src_valid), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int c, input bit e_busy, input bit e_en,
                         input bit e_done, input bit e_err);
    chk($sformatf("t%0d.busy@%0d", txn_no, c), {31'd0, busy}, {31'd0, e_busy});
    chk($sformatf("t%0d.wb_en@%0d", txn_no, c), {31'd0, wb_en}, {31'd0, e_en});
    chk($sformatf("t%0d.done@%0d", txn_no, c), {31'd0, done}, {31'd0, e_done});
    chk($sformatf("t%0d.error@%0d", txn_no, c), {31'd0, error}, {31'd0, e_err});
    chk($sformatf("t%0d.wb_addr@%0d", txn_no, c), {27'd0, wb_addr}, mod_addr);
    chk($sformatf("t%0d.wb_data@%0d", txn_no, c), wb_data, mod_data);
  endtask

  // One request: selected source turns valid d cycles after the request cycle.
  // abort_kind: 0 none, 1 flush, 2 reset, asserted in cycle abort_at.
  task automatic run_txn(input int sel, input int dest, input int d,
                         input logic [31:0] val, input int abort_kind, input int abort_at);
    bit   is_write = 0;
    bit   is_err = 0;
    bit   aborted = 0;
    int   end_c;
    int   busy_end;
    logic [31:0] new_data = 32'd0;
    string outcome;

    if (sel >= NSRC) begin
      is_err = 1; end_c = 1; busy_end = 0;
    end else begin
      int eff = (sel == CSEL) ? 0 : d;
      if (eff <= TOUT) begin
        is_write = 1; end_c = eff + 1; busy_end = end_c;
        new_data = (sel == CSEL) ? 32'd227 : val;
      end else begin
        is_err = 1; end_c = TOUT + 1; busy_end = TOUT;
      end
    end
    if (abort_kind != 0 && abort_at < end_c) begin
      aborted = 1; is_write = 0; is_err = 0;
      busy_end = abort_at; end_c = abort_at + 1;
    end

    for (int c = 0; c <= end_c; c++) begin
      if (c == end_c && is_write) begin
        mod_addr = dest;
        mod_data = new_data;
      end
      if (c == end_c && aborted && abort_kind == 2) begin
        mod_addr = 0;
        mod_data = 0;
      end
      chk_all(c, (c >= 1 && c <= busy_end), (is_write && c == end_c && dest != 0),
              (is_write && c == end_c), (is_err && c == end_c));

      reset = (abort_kind == 2 && c == abort_at);
      flush = (abort_kind == 1 && c == abort_at);
      if (c == 0) begin
        wb_req = 1'b1; wb_sel = sel[2:0]; wb_dest = dest[4:0];
      end else if (c <= busy_end && c < end_c) begin
        wb_req = $urandom_range(0, 1) == 1; wb_sel = 3'($urandom); wb_dest = 5'($urandom);
      end else begin
        wb_req = 1'b0; wb_sel = 3'($urandom); wb_dest = 5'($urandom);
      end
      for (int i = 0; i < NSRC; i++) begin
        src_data[i*32 +: 32] = $urandom;
        src_valid[i] = $urandom_range(0, 1) == 1;
      end
      if (sel < NSRC && sel != CSEL) begin
        src_valid[sel] = (c >= d);
        if (c == d) src_data[sel*32 +: 32] = val;
      end
      @(posedge clk);
      #1;
    end

    outcome = aborted ? "abort" : (is_write ? (dest != 0 ? "write" : "suppressed") : "error");
    $display("txn %0d sel=%0d dest=%0d delay=%0d abort=%0d@%0d outcome=%s cycles=%0d",
             txn_no, sel, dest, d, abort_kind, abort_at, outcome, end_c);
    txn_no++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_req = 1'b0; wb_sel = '0; wb_dest = '0;
    src_data = '0; src_valid = '0;
    mod_addr = 0; mod_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all(0, 0, 0, 0, 0);
    reset = 1'b0;

    run_txn(0, 8, 0, 32'h12345678, 0, 0);
    run_txn(2, 9, 3, 32'hDEADBEEF, 0, 0);
    run_txn(5, 10, 0, 32'hFFFFFFFF, 0, 0);
    run_txn(7, 3, 0, 32'h0BADF00D, 0, 0);
    run_txn(3, 4, 100, 32'h55AA55AA, 0, 0);
    run_txn(3, 4, 100, 32'h55AA55AA, 1, 6);
    run_txn(0, 0, 0, 32'hCAFEF00D, 0, 0);
    run_txn(1, 12, 50, 32'h13579BDF, 2, 4);
    run_txn(4, 17, 16, 32'hA5A5A5A5, 0, 0);
    run_txn(6, 18, 17, 32'h5A5A5A5A, 0, 0);
    run_txn(1, 19, 0, 32'h00000001, 1, 0);

    for (int n = 0; n < 150; n++) begin
      int r = $urandom_range(0, 9);
      run_txn($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 20), $urandom,
              (r == 0) ? 2 : ((r <= 2) ? 1 : 0), $urandom_range(0, 18));
    end

    chk_all(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_select_unit.md
Name: writeback_select_unit

Overview:
Parametrised, sequential successor to the register-file writeback selector of the multicycle CPU. It picks one of NUM_SRC result sources, including a built-in constant source, and waits until the selected source reports valid. This lets slow producers such as mult/div HI/LO finish first. It then issues a single registered write (address, data, enable pulse) to the register bank. The control unit starts it with a one-cycle request and gets done/error status back instead of timing the write itself.

Parameters:
DATA_W, 32, width of each source and of wb_data
NUM_SRC, 7, number of selectable sources; index range 0..NUM_SRC-1
SEL_W, 3, width of wb_sel; NUM_SRC <= 2**SEL_W required
CONST_SEL, 5, source index replaced by the internal constant
CONST_VALUE, 227, constant driven when CONST_SEL is selected
ADDR_W, 5, register-bank address width
TIMEOUT, 63, max cycles waiting for a valid source; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  abort current operation, no write
wb_req  in  1  start pulse; sampled only in IDLE
wb_sel  in  SEL_W  source index, sampled with wb_req
wb_dest  in  ADDR_W  destination register, sampled with wb_req
src_data  in  NUM_SRC*DATA_W  flattened sources; source i = bits [i*DATA_W +: DATA_W]
src_valid  in  NUM_SRC  per-source valid; bit CONST_SEL ignored (constant always valid)
wb_en  out  1  register-bank write enable, one-cycle pulse
wb_addr  out  ADDR_W  registered destination
wb_data  out  DATA_W  registered write data
busy  out  1  high in WAIT and WRITE
done  out  1  one-cycle pulse: operation completed (write or suppressed write)
error  out  1  one-cycle pulse: invalid select or timeout

Behaviour:
- States: IDLE, WAIT, WRITE.
- Reset (synchronous): state IDLE. wb_en, done, error, busy, wb_addr, wb_data and the wait counter all 0. Reset mid-operation aborts with no write.
- IDLE, wb_req=1:
  - Latch sel_q=wb_sel, dest_q=wb_dest.
  - If wb_sel >= NUM_SRC: error=1 next cycle, stay IDLE, no write.
  - Else if the selected source is valid this cycle: capture data into wb_data, go WRITE (latency 1: wb_en high the cycle after wb_req).
  - Else: go WAIT with counter=0.
- WAIT:
  - Each cycle check src_valid[sel_q] (CONST_SEL always valid).
  - On valid: capture data, go WRITE.
  - Else increment counter. If TIMEOUT!=0 and counter reaches TIMEOUT-1 while still not valid: error pulse, go IDLE. Error is asserted exactly TIMEOUT cycles after WAIT entry.
- WRITE (exactly one cycle): done=1, wb_addr=dest_q. wb_en=1 unless dest_q==0; a $0 write is suppressed but done still pulses. Next state IDLE.
- Selected data is src_data slice sel_q, or CONST_VALUE zero-extended/truncated to DATA_W when sel_q==CONST_SEL. It is sampled only on the capture edge. Later changes on src_data do not affect wb_data.
- wb_data and wb_addr hold their last values after WRITE until the next capture. wb_en, done and error are single-cycle pulses and never overlap.
- wb_req while busy is ignored, not queued.
- flush=1: next state IDLE from any state. No write, no done, no error. flush has priority over wb_req, valid and timeout in the same cycle. reset has priority over flush.
- IDLE back-to-back: a wb_req in the cycle after WRITE is accepted normally. Minimum spacing between writes is 2 cycles.

Test Plan:
1. reset, then wb_req sel=0 dest=8, src0=0x12345678 valid -> next cycle wb_en=1, done=1, wb_addr=8, wb_data=0x12345678. Pulses last 1 cycle; busy high 1 cycle.
2. sel=2 dest=9, src_valid[2] low for 3 cycles, then high with 0xDEADBEEF -> busy 4 cycles, wb_en the cycle after valid rises, wb_data=0xDEADBEEF. A second wb_req during WAIT is ignored.
3. sel=5 dest=10, src5 bus=0xFFFFFFFF, valid=0 -> latency 1, wb_data=0x000000E3.
4. sel=7 (NUM_SRC=7) -> error pulse next cycle, no wb_en, no done, busy stays 0.
5. TIMEOUT=16, sel=3, src_valid[3] never high -> error exactly 16 cycles after WAIT entry, busy drops, no write. Repeat with flush at WAIT cycle 5 -> IDLE, no error, no write.
6. sel=0 dest=0 valid -> done=1, wb_en=0. Reset asserted in WAIT -> all outputs 0 next cycle, no write.
